// File: rtl/axi4_id_flight_limiter.sv
// Per-ID outstanding-burst limiter between the AXI4 ID-folding stage and the slave port.
// Gates AW/AR when an ID is at its limit and holds W until a matching AW has been accepted.
module axi4_id_flight_limiter #(
    parameter int ID_BITS    = 1,
    parameter int MAX_FLIGHT = 4,
    parameter int W_PEND     = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               aw_in_valid,
    output logic               aw_in_ready,
    input  logic [ID_BITS-1:0] aw_id,
    output logic               aw_out_valid,
    input  logic               aw_out_ready,
    input  logic               w_in_valid,
    output logic               w_in_ready,
    input  logic               w_last,
    output logic               w_out_valid,
    input  logic               w_out_ready,
    input  logic               b_valid,
    input  logic               b_ready,
    input  logic [ID_BITS-1:0] b_id,
    input  logic               ar_in_valid,
    output logic               ar_in_ready,
    input  logic [ID_BITS-1:0] ar_id,
    output logic               ar_out_valid,
    input  logic               ar_out_ready,
    input  logic               r_valid,
    input  logic               r_ready,
    input  logic [ID_BITS-1:0] r_id,
    input  logic               r_last
);

    localparam int NID = 2 ** ID_BITS;
    localparam int CW  = $clog2(MAX_FLIGHT + 1);
    localparam int PW  = $clog2(W_PEND + 1);

    logic [CW-1:0]  wr_cnt [NID];
    logic [CW-1:0]  rd_cnt [NID];
    logic [PW-1:0]  wpend;

    logic           aw_ok, ar_ok, w_ok;
    logic           aw_fire, ar_fire, w_last_fire, b_fire, r_last_fire;
    logic [NID-1:0] wr_inc, wr_dec, rd_inc, rd_dec;

    // Gates look only at registered counts, so a slot freed this cycle is usable next cycle.
    assign aw_ok = (wr_cnt[aw_id] < CW'(MAX_FLIGHT)) && (wpend < PW'(W_PEND)) && !reset;
    assign ar_ok = (rd_cnt[ar_id] < CW'(MAX_FLIGHT)) && !reset;
    assign w_ok  = (wpend != '0) && !reset;

    assign aw_out_valid = aw_in_valid & aw_ok;
    assign aw_in_ready  = aw_out_ready & aw_ok;
    assign ar_out_valid = ar_in_valid & ar_ok;
    assign ar_in_ready  = ar_out_ready & ar_ok;
    assign w_out_valid  = w_in_valid & w_ok;
    assign w_in_ready   = w_out_ready & w_ok;

    assign aw_fire     = aw_out_valid & aw_out_ready;
    assign ar_fire     = ar_out_valid & ar_out_ready;
    assign w_last_fire = w_out_valid & w_out_ready & w_last;
    assign b_fire      = b_valid & b_ready;
    assign r_last_fire = r_valid & r_ready & r_last;

    always_comb begin
        wr_inc = '0;
        wr_dec = '0;
        rd_inc = '0;
        rd_dec = '0;
        for (int unsigned i = 0; i < NID; i++) begin
            wr_inc[i] = aw_fire     && (aw_id == ID_BITS'(i));
            wr_dec[i] = b_fire      && (b_id  == ID_BITS'(i));
            rd_inc[i] = ar_fire     && (ar_id == ID_BITS'(i));
            rd_dec[i] = r_last_fire && (r_id  == ID_BITS'(i));
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < NID; i++) begin
                wr_cnt[i] <= '0;
                rd_cnt[i] <= '0;
            end
            wpend <= '0;
        end else begin
            // Decrement at zero is a protocol error; the count saturates instead of wrapping.
            for (int unsigned i = 0; i < NID; i++) begin
                if (wr_inc[i] && !wr_dec[i])
                    wr_cnt[i] <= wr_cnt[i] + CW'(1);
                else if (wr_dec[i] && !wr_inc[i] && wr_cnt[i] != '0)
                    wr_cnt[i] <= wr_cnt[i] - CW'(1);

                if (rd_inc[i] && !rd_dec[i])
                    rd_cnt[i] <= rd_cnt[i] + CW'(1);
                else if (rd_dec[i] && !rd_inc[i] && rd_cnt[i] != '0)
                    rd_cnt[i] <= rd_cnt[i] - CW'(1);
            end
            if (aw_fire && !w_last_fire)
                wpend <= wpend + PW'(1);
            else if (w_last_fire && !aw_fire)
                wpend <= wpend - PW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && b_fire)
            assert (wr_cnt[b_id] != '0 || wr_inc[b_id])
            else $warning("B response on id %0d with no write outstanding", b_id);
        if (!reset && r_last_fire)
            assert (rd_cnt[r_id] != '0 || rd_inc[r_id])
            else $warning("R last on id %0d with no read outstanding", r_id);
    end

endmodule
